// File: rtl/sha_work_feeder_pkg.sv
// Shared SHA-256 feeder types and constants.
package sha_work_feeder_pkg;
  localparam int WORD_W      = 32;
  localparam int HASH_WORDS  = 8;
  localparam int BLOCK_WORDS = 16;
  localparam int TAIL_WORDS  = 3;

  // Chunk-2 padding: the 0x80 marker byte right after the nonce, and the
  // 640-bit (80-byte header) message length in the final word.
  localparam logic [WORD_W-1:0] PAD_ONE = 32'h8000_0000;
  localparam logic [WORD_W-1:0] PAD_LEN = 32'h0000_0280;

  localparam logic [3:0] LAST_WORD = 4'(BLOCK_WORDS - 1);

  typedef logic [HASH_WORDS-1:0][WORD_W-1:0] hash_state_t;
  typedef logic [TAIL_WORDS-1:0][WORD_W-1:0] tail_t;

  typedef enum logic {S_IDLE, S_ISSUE} feed_state_e;
endpackage

// File: rtl/sha_work_feeder_word_mux.sv
// Chunk-2 message word select: tail words, nonce, then fixed padding.
module sha_work_word_mux
  import sha_work_feeder_pkg::*;
(
  input  logic [3:0]        word_idx,
  input  tail_t             tail,
  input  logic [WORD_W-1:0] nonce,
  output logic [WORD_W-1:0] data
);
  // Words 5..14 are zero padding, covered by the default.
  always_comb begin
    data = '0;
    case (word_idx)
      4'd0, 4'd1, 4'd2: data = tail[word_idx[1:0]];
      4'd3:             data = nonce;
      4'd4:             data = PAD_ONE;
      LAST_WORD:        data = PAD_LEN;
      default:          data = '0;
    endcase
  end
endmodule

// File: rtl/sha_work_feeder.sv
// Expands a work unit into a stream of 16-word chunk-2 blocks, one per nonce.
module sha_work_feeder
  import sha_work_feeder_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              work_valid,
  output logic              work_ready,
  input  hash_state_t       work_midstate,
  input  tail_t             work_tail,
  input  logic [WORD_W-1:0] work_nonce_start,
  input  logic [WORD_W-1:0] work_nonce_count,
  input  logic              abort,
  output logic              core_valid,
  output logic              core_newblock,
  output hash_state_t       core_hashstate,
  output logic [WORD_W-1:0] core_data,
  output logic [WORD_W-1:0] core_nonce,
  output logic              done
);
  feed_state_e       state_q, state_d;
  logic [3:0]        idx_q, idx_d;
  logic [WORD_W:0]   remaining_q, remaining_d;
  tail_t             tail_q, tail_d;
  logic              abort_q, abort_d;
  logic [WORD_W-1:0] nonce_d;
  logic              accept, last, issue_d;
  logic [WORD_W-1:0] mux_data;

  // work_ready is a register, so gating on it keeps the handshake exact.
  assign accept  = work_valid & work_ready;
  assign issue_d = (state_d == S_ISSUE);

  // Outputs are registered from next-state values so word 0 appears the
  // cycle after acceptance.
  sha_work_word_mux u_mux (
    .word_idx (idx_d),
    .tail     (tail_d),
    .nonce    (nonce_d),
    .data     (mux_data)
  );

  // Next-state: accept, walk 16 words per block, step nonce between blocks.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    remaining_d = remaining_q;
    tail_d      = tail_q;
    nonce_d     = core_nonce;
    abort_d     = abort_q;
    last        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d     = S_ISSUE;
          idx_d       = '0;
          tail_d      = work_tail;
          nonce_d     = work_nonce_start;
          remaining_d = (work_nonce_count == '0) ? {1'b1, {WORD_W{1'b0}}}
                                                 : {1'b0, work_nonce_count};
        end
      end
      S_ISSUE: begin
        if (abort) abort_d = 1'b1;
        if (idx_q == LAST_WORD) begin
          idx_d       = '0;
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == 1 || abort_q || abort) begin
            state_d = S_IDLE;
            last    = 1'b1;
          end else begin
            // Nonce only advances when another block follows, so
            // core_nonce keeps the last issued nonce while idle.
            nonce_d = core_nonce + 1'b1;
          end
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_IDLE) abort_d = 1'b0;
  end

  // State and registered outputs; async reset drops any block in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      idx_q          <= '0;
      remaining_q    <= '0;
      tail_q         <= '0;
      abort_q        <= 1'b0;
      work_ready     <= 1'b0;
      core_valid     <= 1'b0;
      core_newblock  <= 1'b0;
      core_hashstate <= '0;
      core_data      <= '0;
      core_nonce     <= '0;
      done           <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      remaining_q   <= remaining_d;
      tail_q        <= tail_d;
      abort_q       <= abort_d;
      work_ready    <= ~issue_d;
      core_valid    <= issue_d;
      core_newblock <= issue_d && (idx_d == '0);
      core_data     <= issue_d ? mux_data : '0;
      core_nonce    <= nonce_d;
      done          <= last;
      if (accept) core_hashstate <= work_midstate;
    end
  end
endmodule

// File: tb/tb_sha_work_feeder.sv
// Directed bench for sha_work_feeder.
module tb_sha_work_feeder;
  import sha_work_feeder_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        work_valid = 1'b0;
  logic        work_ready;
  hash_state_t work_midstate = '0;
  tail_t       work_tail = '0;
  logic [31:0] work_nonce_start = '0;
  logic [31:0] work_nonce_count = '0;
  logic        abort = 1'b0;
  logic        core_valid, core_newblock, done;
  hash_state_t core_hashstate;
  logic [31:0] core_data, core_nonce;

  int total = 0;
  int bad   = 0;

  localparam hash_state_t MS = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  always #5 clk = ~clk;

  sha_work_feeder dut (
    .clk(clk), .rst(rst),
    .work_valid(work_valid), .work_ready(work_ready),
    .work_midstate(work_midstate), .work_tail(work_tail),
    .work_nonce_start(work_nonce_start), .work_nonce_count(work_nonce_count),
    .abort(abort),
    .core_valid(core_valid), .core_newblock(core_newblock),
    .core_hashstate(core_hashstate), .core_data(core_data),
    .core_nonce(core_nonce), .done(done)
  );

  function automatic logic [31:0] exp_word(input int i, input logic [31:0] t0, t1, t2, n);
    case (i)
      0: return t0;
      1: return t1;
      2: return t2;
      3: return n;
      4: return 32'h8000_0000;
      15: return 32'h0000_0280;
      default: return 32'h0;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge where word 0 is visible.
  task automatic issue_work(input logic [31:0] t0, t1, t2, ns, cnt);
    total++;
    if (work_ready !== 1'b1) begin
      bad++;
      $display("FAIL issue_ready: work_ready=%b want 1", work_ready);
    end
    work_valid = 1'b1;
    work_midstate = MS;
    work_tail = {t2, t1, t0};
    work_nonce_start = ns;
    work_nonce_count = cnt;
    @(posedge clk);
    @(negedge clk);
    work_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (work_ready !== 0 || core_valid !== 0 || core_newblock !== 0 || core_data !== 0 ||
        core_nonce !== 0 || core_hashstate !== '0 || done !== 0) begin
      bad++;
      $display("FAIL reset_outputs: ready=%b valid=%b nb=%b data=%h nonce=%h done=%b want all 0",
               work_ready, core_valid, core_newblock, core_data, core_nonce, done);
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (work_ready !== 1'b1 || core_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_ready: ready=%b valid=%b want 1 0", work_ready, core_valid);
    end
  endtask

  task automatic test_single;
    issue_work(32'd1, 32'd2, 32'd3, 32'h10, 32'd1);
    for (int i = 0; i < 16; i++) begin
      total++;
      if (core_valid !== 1 || core_newblock !== (i == 0) || core_data !== exp_word(i, 1, 2, 3, 32'h10) ||
          core_nonce !== 32'h10 || core_hashstate !== MS || work_ready !== 0 || done !== 0) begin
        bad++;
        $display("FAIL single_word%0d: valid=%b nb=%b data=%h nonce=%h ready=%b done=%b want data=%h",
                 i, core_valid, core_newblock, core_data, core_nonce, work_ready, done,
                 exp_word(i, 1, 2, 3, 32'h10));
      end
      @(negedge clk);
    end
    total++;
    if (done !== 1 || core_valid !== 0 || core_data !== 0 || work_ready !== 1 ||
        core_nonce !== 32'h10 || core_hashstate !== MS) begin
      bad++;
      $display("FAIL single_done: done=%b valid=%b data=%h ready=%b nonce=%h want 1 0 0 1 10",
               done, core_valid, core_data, work_ready, core_nonce);
    end
    @(negedge clk);
    total++;
    if (done !== 0) begin
      bad++;
      $display("FAIL single_done_pulse: done=%b want 0", done);
    end
  endtask

  task automatic test_wrap;
    int dones = 0;
    logic [31:0] n;
    issue_work(32'haaaa0000, 32'hbbbb1111, 32'hcccc2222, 32'hFFFFFFFE, 32'd3);
    for (int i = 0; i < 48; i++) begin
      n = 32'hFFFFFFFE + 32'(i / 16);
      if (done === 1'b1) dones++;
      total++;
      if (core_valid !== 1 || core_newblock !== (i % 16 == 0) || core_nonce !== n ||
          core_data !== exp_word(i % 16, 32'haaaa0000, 32'hbbbb1111, 32'hcccc2222, n)) begin
        bad++;
        $display("FAIL wrap_word%0d: valid=%b nb=%b data=%h nonce=%h want nonce=%h data=%h",
                 i, core_valid, core_newblock, core_data, core_nonce, n,
                 exp_word(i % 16, 32'haaaa0000, 32'hbbbb1111, 32'hcccc2222, n));
      end
      @(negedge clk);
    end
    if (done === 1'b1) dones++;
    @(negedge clk);
    if (done === 1'b1) dones++;
    total++;
    if (dones != 1 || core_valid !== 0 || core_nonce !== 32'h0) begin
      bad++;
      $display("FAIL wrap_done: dones=%0d valid=%b nonce=%h want 1 0 00000000", dones, core_valid, core_nonce);
    end
  endtask

  task automatic test_abort;
    int words = 0;
    int dones = 0;
    issue_work(32'd4, 32'd5, 32'd6, 32'h300, 32'd5);
    for (int c = 0; c < 200 && dones == 0; c++) begin
      if (core_valid === 1'b1) begin
        words++;
        abort = (words == 24);
      end else begin
        abort = 1'b0;
      end
      if (done === 1'b1) dones++;
      @(negedge clk);
    end
    abort = 1'b0;
    total++;
    if (words != 32 || dones != 1 || work_ready !== 1 || core_valid !== 0) begin
      bad++;
      $display("FAIL abort_words: words=%0d dones=%0d ready=%b valid=%b want 32 1 1 0",
               words, dones, work_ready, core_valid);
    end
  endtask

  task automatic test_abort_idle;
    int words = 0;
    int dones = 0;
    abort = 1'b1;
    repeat (3) @(negedge clk);
    abort = 1'b0;
    issue_work(32'd7, 32'd8, 32'd9, 32'h400, 32'd2);
    for (int c = 0; c < 100 && dones == 0; c++) begin
      if (core_valid === 1'b1) words++;
      if (done === 1'b1) dones++;
      @(negedge clk);
    end
    total++;
    if (words != 32 || dones != 1) begin
      bad++;
      $display("FAIL abort_idle: words=%0d dones=%0d want 32 1", words, dones);
    end
  endtask

  task automatic test_back_to_back;
    work_valid = 1'b1;
    work_midstate = MS;
    work_tail = {32'd3, 32'd2, 32'd1};
    work_nonce_start = 32'h100;
    work_nonce_count = 32'd1;
    @(posedge clk);
    @(negedge clk);
    work_nonce_start = 32'h200;
    for (int i = 0; i < 16; i++) begin
      total++;
      if (core_valid !== 1 || work_ready !== 0 || core_nonce !== 32'h100 ||
          core_data !== exp_word(i, 1, 2, 3, 32'h100)) begin
        bad++;
        $display("FAIL b2b_first%0d: valid=%b ready=%b nonce=%h data=%h want 1 0 100",
                 i, core_valid, work_ready, core_nonce, core_data);
      end
      @(negedge clk);
    end
    total++;
    if (core_valid !== 0 || work_ready !== 1 || done !== 1) begin
      bad++;
      $display("FAIL b2b_gap: valid=%b ready=%b done=%b want 0 1 1", core_valid, work_ready, done);
    end
    @(negedge clk);
    work_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      total++;
      if (core_valid !== 1 || work_ready !== 0 || core_newblock !== (i == 0) ||
          core_nonce !== 32'h200 || core_data !== exp_word(i, 1, 2, 3, 32'h200)) begin
        bad++;
        $display("FAIL b2b_second%0d: valid=%b ready=%b nb=%b nonce=%h data=%h want nonce 200",
                 i, core_valid, work_ready, core_newblock, core_nonce, core_data);
      end
      @(negedge clk);
    end
    total++;
    if (done !== 1) begin
      bad++;
      $display("FAIL b2b_done: done=%b want 1", done);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int dones = 0;
    issue_work(32'h11, 32'h22, 32'h33, 32'h55, 32'd2);
    repeat (9) @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (core_valid !== 0 || core_data !== 0 || core_nonce !== 0 || core_hashstate !== '0 ||
        core_newblock !== 0 || work_ready !== 0 || done !== 0) begin
      bad++;
      $display("FAIL rstmid_async: valid=%b data=%h nonce=%h nb=%b ready=%b done=%b want all 0",
               core_valid, core_data, core_nonce, core_newblock, work_ready, done);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done === 1'b1 || core_valid === 1'b1) dones++;
    end
    total++;
    if (dones != 0 || work_ready !== 1) begin
      bad++;
      $display("FAIL rstmid_quiet: stray=%0d ready=%b want 0 1", dones, work_ready);
    end
    issue_work(32'h7, 32'h8, 32'h9, 32'h77, 32'd1);
    total++;
    if (core_valid !== 1 || core_newblock !== 1 || core_data !== 32'h7 || core_nonce !== 32'h77) begin
      bad++;
      $display("FAIL rstmid_restart: valid=%b nb=%b data=%h nonce=%h want 1 1 7 77",
               core_valid, core_newblock, core_data, core_nonce);
    end
    repeat (16) @(negedge clk);
    total++;
    if (done !== 1) begin
      bad++;
      $display("FAIL rstmid_done: done=%b want 1", done);
    end
    @(negedge clk);
  endtask

  task automatic test_count0;
    int dones = 0;
    issue_work(32'h1, 32'h2, 32'h3, 32'h1000, 32'd0);
    repeat (1600) @(negedge clk);
    total++;
    if (core_valid !== 1 || core_newblock !== 1 || work_ready !== 0 ||
        dut.remaining_q !== 33'h0_FFFF_FF9C || core_nonce !== 32'h1064) begin
      bad++;
      $display("FAIL count0_run: valid=%b nb=%b ready=%b rem=%h nonce=%h want 1 1 0 0ffffff9c 1064",
               core_valid, core_newblock, work_ready, dut.remaining_q, core_nonce);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    for (int c = 0; c < 30 && dones == 0; c++) begin
      if (done === 1'b1) dones++;
      @(negedge clk);
    end
    total++;
    if (dones != 1 || work_ready !== 1) begin
      bad++;
      $display("FAIL count0_abort: dones=%0d ready=%b want 1 1", dones, work_ready);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_abort();
    test_abort_idle();
    test_back_to_back();
    test_reset_mid();
    test_count0();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
